// File: rtl/dbg_inst_encoder_pkg.sv
// Shared definitions for the debug instruction encoder: debug op codes, MIPS
// opcode/funct constants, FSM state type and the combinational encode function.
package dbg_inst_encoder_pkg;

  localparam int unsigned Width = 32;

  // Debug-port operation codes (6-bit)
  localparam logic [5:0] DbgOpAdd   = 6'd0;
  localparam logic [5:0] DbgOpAddu  = 6'd1;
  localparam logic [5:0] DbgOpSub   = 6'd2;
  localparam logic [5:0] DbgOpSubu  = 6'd3;
  localparam logic [5:0] DbgOpSlt   = 6'd4;
  localparam logic [5:0] DbgOpSltu  = 6'd5;
  localparam logic [5:0] DbgOpAnd   = 6'd6;
  localparam logic [5:0] DbgOpOr    = 6'd7;
  localparam logic [5:0] DbgOpXor   = 6'd8;
  localparam logic [5:0] DbgOpNor   = 6'd9;
  localparam logic [5:0] DbgOpSll   = 6'd10;
  localparam logic [5:0] DbgOpSrl   = 6'd11;
  localparam logic [5:0] DbgOpSra   = 6'd12;
  localparam logic [5:0] DbgOpSllv  = 6'd13;
  localparam logic [5:0] DbgOpSrlv  = 6'd14;
  localparam logic [5:0] DbgOpSrav  = 6'd15;
  localparam logic [5:0] DbgOpJr    = 6'd16;
  localparam logic [5:0] DbgOpJalr  = 6'd17;
  localparam logic [5:0] DbgOpAddi  = 6'd18;
  localparam logic [5:0] DbgOpAddiu = 6'd19;
  localparam logic [5:0] DbgOpAndi  = 6'd20;
  localparam logic [5:0] DbgOpOri   = 6'd21;
  localparam logic [5:0] DbgOpXori  = 6'd22;
  localparam logic [5:0] DbgOpSlti  = 6'd23;
  localparam logic [5:0] DbgOpSltiu = 6'd24;
  localparam logic [5:0] DbgOpLui   = 6'd25;
  localparam logic [5:0] DbgOpLw    = 6'd26;
  localparam logic [5:0] DbgOpSw    = 6'd27;
  localparam logic [5:0] DbgOpBeq   = 6'd28;
  localparam logic [5:0] DbgOpBne   = 6'd29;
  localparam logic [5:0] DbgOpJ     = 6'd30;
  localparam logic [5:0] DbgOpJal   = 6'd31;
  localparam logic [5:0] DbgOpLi32  = 6'd32;
  localparam logic [5:0] DbgOpNop   = 6'd33;

  // MIPS primary opcodes
  localparam logic [5:0] OpcSpecial = 6'h00;
  localparam logic [5:0] OpcJ       = 6'h02;
  localparam logic [5:0] OpcJal     = 6'h03;
  localparam logic [5:0] OpcBeq     = 6'h04;
  localparam logic [5:0] OpcBne     = 6'h05;
  localparam logic [5:0] OpcAddi    = 6'h08;
  localparam logic [5:0] OpcAddiu   = 6'h09;
  localparam logic [5:0] OpcSlti    = 6'h0A;
  localparam logic [5:0] OpcSltiu   = 6'h0B;
  localparam logic [5:0] OpcAndi    = 6'h0C;
  localparam logic [5:0] OpcOri     = 6'h0D;
  localparam logic [5:0] OpcXori    = 6'h0E;
  localparam logic [5:0] OpcLui     = 6'h0F;
  localparam logic [5:0] OpcLw      = 6'h23;
  localparam logic [5:0] OpcSw      = 6'h2B;

  // MIPS SPECIAL funct codes
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  typedef enum logic [0:0] {StIdle, StSecond} state_e;

  typedef struct packed {
    logic             legal;     // op code is defined
    logic             two_word;  // op always expands to two words
    logic             ctrl;      // branch/jump, eligible for a delay-slot NOP
    logic [Width-1:0] word0;
    logic [Width-1:0] word1;
  } enc_t;

  function automatic logic [Width-1:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [4:0] shamt,
                                              input logic [5:0] funct);
    return {OpcSpecial, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [Width-1:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic enc_t encode(input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [Width-1:0] imm);
    enc_t e;
    e       = '0;
    e.legal = 1'b1;
    case (op)
      DbgOpAdd:   e.word0 = r_word(rs, rt, rd, 5'd0, FnAdd);
      DbgOpAddu:  e.word0 = r_word(rs, rt, rd, 5'd0, FnAddu);
      DbgOpSub:   e.word0 = r_word(rs, rt, rd, 5'd0, FnSub);
      DbgOpSubu:  e.word0 = r_word(rs, rt, rd, 5'd0, FnSubu);
      DbgOpSlt:   e.word0 = r_word(rs, rt, rd, 5'd0, FnSlt);
      DbgOpSltu:  e.word0 = r_word(rs, rt, rd, 5'd0, FnSltu);
      DbgOpAnd:   e.word0 = r_word(rs, rt, rd, 5'd0, FnAnd);
      DbgOpOr:    e.word0 = r_word(rs, rt, rd, 5'd0, FnOr);
      DbgOpXor:   e.word0 = r_word(rs, rt, rd, 5'd0, FnXor);
      DbgOpNor:   e.word0 = r_word(rs, rt, rd, 5'd0, FnNor);
      // Immediate shifts: rs field is architecturally zero
      DbgOpSll:   e.word0 = r_word(5'd0, rt, rd, imm[4:0], FnSll);
      DbgOpSrl:   e.word0 = r_word(5'd0, rt, rd, imm[4:0], FnSrl);
      DbgOpSra:   e.word0 = r_word(5'd0, rt, rd, imm[4:0], FnSra);
      DbgOpSllv:  e.word0 = r_word(rs, rt, rd, 5'd0, FnSllv);
      DbgOpSrlv:  e.word0 = r_word(rs, rt, rd, 5'd0, FnSrlv);
      DbgOpSrav:  e.word0 = r_word(rs, rt, rd, 5'd0, FnSrav);
      DbgOpJr: begin
        e.word0 = r_word(rs, 5'd0, 5'd0, 5'd0, FnJr);
        e.ctrl  = 1'b1;
      end
      DbgOpJalr: begin
        e.word0 = r_word(rs, 5'd0, rd, 5'd0, FnJalr);
        e.ctrl  = 1'b1;
      end
      DbgOpAddi:  e.word0 = i_word(OpcAddi, rs, rt, imm[15:0]);
      DbgOpAddiu: e.word0 = i_word(OpcAddiu, rs, rt, imm[15:0]);
      DbgOpAndi:  e.word0 = i_word(OpcAndi, rs, rt, imm[15:0]);
      DbgOpOri:   e.word0 = i_word(OpcOri, rs, rt, imm[15:0]);
      DbgOpXori:  e.word0 = i_word(OpcXori, rs, rt, imm[15:0]);
      DbgOpSlti:  e.word0 = i_word(OpcSlti, rs, rt, imm[15:0]);
      DbgOpSltiu: e.word0 = i_word(OpcSltiu, rs, rt, imm[15:0]);
      DbgOpLui:   e.word0 = i_word(OpcLui, 5'd0, rt, imm[15:0]);
      DbgOpLw:    e.word0 = i_word(OpcLw, rs, rt, imm[15:0]);
      DbgOpSw:    e.word0 = i_word(OpcSw, rs, rt, imm[15:0]);
      DbgOpBeq: begin
        e.word0 = i_word(OpcBeq, rs, rt, imm[15:0]);
        e.ctrl  = 1'b1;
      end
      DbgOpBne: begin
        e.word0 = i_word(OpcBne, rs, rt, imm[15:0]);
        e.ctrl  = 1'b1;
      end
      DbgOpJ: begin
        e.word0 = {OpcJ, imm[25:0]};
        e.ctrl  = 1'b1;
      end
      DbgOpJal: begin
        e.word0 = {OpcJal, imm[25:0]};
        e.ctrl  = 1'b1;
      end
      // LUI rt,hi then ORI rt,rt,lo
      DbgOpLi32: begin
        e.word0    = i_word(OpcLui, 5'd0, rt, imm[31:16]);
        e.word1    = i_word(OpcOri, rt, rt, imm[15:0]);
        e.two_word = 1'b1;
      end
      DbgOpNop:   e.word0 = '0;
      default:    e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dbg_inst_encoder_sync_fifo.sv
// Synchronous FIFO with registered head, occupancy count and synchronous flush.
// Push is refused while full even if a pop happens in the same cycle.
module dbg_inst_encoder_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             pop_i,
  output logic [DW-1:0]    rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LVL_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign level_o = count_q;
  // Empty FIFO presents zero so the head reads as 0 out of reset
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // Storage write
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dbg_inst_encoder.sv
// Debug-side MIPS instruction encoder: turns abstract debug commands into
// instruction words, expands two-word pseudo-ops and queues words for fetch
// injection. Optional macro DBG_ENC_DELAY_SLOT_EN appends a NOP delay-slot
// word after every branch/jump.
module dbg_inst_encoder
  import dbg_inst_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [5:0]       cmd_op_i,
  input  logic [4:0]       cmd_rs_i,
  input  logic [4:0]       cmd_rt_i,
  input  logic [4:0]       cmd_rd_i,
  input  logic [Width-1:0] cmd_imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_inst_o,
  output logic [LVL_W-1:0] level_o,
  output logic             err_illegal_o
);

`ifdef DBG_ENC_DELAY_SLOT_EN
  localparam bit DelaySlotEn = 1'b1;
`else
  localparam bit DelaySlotEn = 1'b0;
`endif

  state_e           state_q;
  logic [Width-1:0] second_q;
  logic             err_q;

  enc_t             enc;
  logic             two_word;
  logic             accept;
  logic             fifo_full, fifo_empty;
  logic             push;
  logic [Width-1:0] push_data;

  assign enc      = encode(cmd_op_i, cmd_rs_i, cmd_rt_i, cmd_rd_i, cmd_imm_i);
  // Delay-slot word is a NOP, which is already what enc.word1 holds for ctrl ops
  assign two_word = enc.two_word || (DelaySlotEn && enc.ctrl);

  // Ready depends only on FSM state and registered occupancy, never on out_ready
  assign cmd_ready_o   = (state_q == StIdle) && !fifo_full;
  assign accept        = cmd_valid_i && cmd_ready_o;
  assign out_valid_o   = !fifo_empty;
  assign err_illegal_o = err_q;

  // Select which word (if any) enters the FIFO this cycle
  always_comb begin
    push      = 1'b0;
    push_data = enc.word0;
    if (!flush_i) begin
      unique case (state_q)
        StIdle: begin
          push      = accept && enc.legal;
          push_data = enc.word0;
        end
        StSecond: begin
          push      = !fifo_full;
          push_data = second_q;
        end
        default: ;
      endcase
    end
  end

  // Two-state sequencer holding the pending second word and the error pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      second_q <= '0;
      err_q    <= 1'b0;
    end else if (flush_i) begin
      state_q  <= StIdle;
      second_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && !enc.legal;
      unique case (state_q)
        StIdle: begin
          if (accept && enc.legal && two_word) begin
            second_q <= enc.word1;
            state_q  <= StSecond;
          end
        end
        StSecond: begin
          if (!fifo_full) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  dbg_inst_encoder_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (Width),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (out_valid_o && out_ready_i),
    .rdata_o (out_inst_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_dbg_inst_encoder.sv
// Self-checking bench for dbg_inst_encoder: table of encodings plus hand-written
// sequences for pseudo-op expansion, backpressure, illegal ops, flush and reset.
module tb_dbg_inst_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = 3;
`ifdef DBG_ENC_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [5:0]       cmd_op = '0;
  logic [4:0]       cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
  logic [31:0]      cmd_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic [LVL_W-1:0] level;
  logic             err_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [31:0] w0, w1;
    bit          two;
    bit          ctrl;
  } vec_t;

  vec_t vecs[16];

  dbg_inst_encoder #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_rs_i      (cmd_rs),
    .cmd_rt_i      (cmd_rt),
    .cmd_rd_i      (cmd_rd),
    .cmd_imm_i     (cmd_imm),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_inst_o    (out_inst),
    .level_o       (level),
    .err_illegal_o (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed head word must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%08h, expected no word", out_inst);
      end else begin
        check("out_inst", out_inst, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for acceptance, queue its expected words
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm, input int n,
                      input logic [31:0] w0, input logic [31:0] w1);
    bit accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_rd    = rd;
    cmd_imm   = imm;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        if (n >= 1) exp_q.push_back(w0);
        if (n >= 2) exp_q.push_back(w1);
        accepted = 1'b1;
        tick(1);
        break;
      end
      tick(1);
    end
    cmd_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d not accepted, expected acceptance", op);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick(1);
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{"add",   6'd0,  5'd1,  5'd2,  5'd3,  32'h0,        32'h00221820, 32'h0, 0, 0};
    vecs[1]  = '{"sub",   6'd2,  5'd4,  5'd5,  5'd6,  32'h0,        32'h00853022, 32'h0, 0, 0};
    vecs[2]  = '{"sll",   6'd10, 5'd7,  5'd9,  5'd10, 32'hFFFFFFE5, 32'h00095140, 32'h0, 0, 0};
    vecs[3]  = '{"srav",  6'd15, 5'd2,  5'd3,  5'd4,  32'h1F,       32'h00432007, 32'h0, 0, 0};
    vecs[4]  = '{"jr",    6'd16, 5'd31, 5'd5,  5'd6,  32'h1F,       32'h03E00008, 32'h0, 0, 1};
    vecs[5]  = '{"jalr",  6'd17, 5'd4,  5'd5,  5'd31, 32'h1F,       32'h0080F809, 32'h0, 0, 1};
    vecs[6]  = '{"addiu", 6'd19, 5'd0,  5'd5,  5'd0,  32'h1234,     32'h24051234, 32'h0, 0, 0};
    vecs[7]  = '{"lui",   6'd25, 5'd7,  5'd8,  5'd0,  32'hFFFFABCD, 32'h3C08ABCD, 32'h0, 0, 0};
    vecs[8]  = '{"sw",    6'd27, 5'd29, 5'd31, 5'd0,  32'h10,       32'hAFBF0010, 32'h0, 0, 0};
    vecs[9]  = '{"beq",   6'd28, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFF, 32'h1022FFFF, 32'h0, 0, 1};
    vecs[10] = '{"j",     6'd30, 5'd0,  5'd0,  5'd0,  32'h0100000,  32'h08100000, 32'h0, 0, 1};
    vecs[11] = '{"jal",   6'd31, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h0FFFFFFF, 32'h0, 0, 1};
    vecs[12] = '{"li32",  6'd32, 5'd0,  5'd8,  5'd0,  32'hDEADBEEF, 32'h3C08DEAD, 32'h3508BEEF, 1, 0};
    vecs[13] = '{"nop",   6'd33, 5'd1,  5'd2,  5'd3,  32'h12345678, 32'h00000000, 32'h0, 0, 0};
    vecs[14] = '{"nor",   6'd9,  5'd1,  5'd2,  5'd3,  32'h0,        32'h00221827, 32'h0, 0, 0};
    vecs[15] = '{"sltiu", 6'd24, 5'd3,  5'd4,  5'd0,  32'h8000,     32'h2C648000, 32'h0, 0, 0};

    // Reset values
    tick(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD: first word visible the cycle after accept
    out_ready = 1'b0;
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1, 32'h00221820, 32'h0);
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_out_inst", out_inst, 32'h00221820);
    check("add_level", 32'(level), 32'd1);
    drain();

    // Encoding table, streamed with the consumer always ready
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      n = (vecs[i].two || (DS && vecs[i].ctrl)) ? 2 : 1;
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, n,
           vecs[i].w0, vecs[i].w1);
    end
    drain();

    // LI32: cmd_ready low for exactly one cycle
    send(6'd32, 5'd0, 5'd8, 5'd0, 32'hDEADBEEF, 2, 32'h3C08DEAD, 32'h3508BEEF);
    check("li32_ready_second", 32'(cmd_ready), 32'd0);
    check("li32_level_first", 32'(level), 32'd1);
    tick(1);
    check("li32_ready_back", 32'(cmd_ready), 32'd1);
    check("li32_level_second", 32'(level), 32'd1);
    drain();

    // Backpressure: fill, then release and watch one pop per cycle
    for (int r = 0; r < 2; r++) begin
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (r == 0) send(6'd33, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0, 32'h0);
        else send(6'd19, 5'd0, 5'(k + 1), 5'd0, 32'(k + 1), 1,
                  32'h24000000 | (32'(k + 1) << 16) | 32'(k + 1), 32'h0);
      end
      check("full_level", 32'(level), 32'd4);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      out_ready = 1'b1;
      for (int k = 3; k >= 0; k--) begin
        tick(1);
        check("bp_level", 32'(level), 32'(k));
      end
      check("bp_out_valid", 32'(out_valid), 32'd0);
    end

    // Illegal op: consumed, pulses err for one cycle, pushes nothing
    out_ready = 1'b0;
    send(6'd33, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0, 32'h0);
    send(6'd40, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 0, 32'h0, 32'h0);
    check("illegal_err_pulse", 32'(err_illegal), 32'd1);
    check("illegal_level", 32'(level), 32'd1);
    tick(1);
    check("illegal_err_clear", 32'(err_illegal), 32'd0);
    drain();

    // Flush while in SECOND discards the pending word
    out_ready = 1'b0;
    send(6'd32, 5'd0, 5'd8, 5'd0, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    check("flush_pre_ready", 32'(cmd_ready), 32'd0);
    check("flush_pre_level", 32'(level), 32'd1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_ready", 32'(cmd_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick(4);

    // Asynchronous reset while in SECOND of LI32
    out_ready = 1'b0;
    send(6'd32, 5'd0, 5'd8, 5'd0, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    check("rst2_pre_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst2_level", 32'(level), 32'd0);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    tick(1);
    check("rst2_ready", 32'(cmd_ready), 32'd1);
    check("rst2_level_after", 32'(level), 32'd0);
    out_ready = 1'b1;
    tick(4);

    // Recovery after reset
    send(6'd19, 5'd0, 5'd5, 5'd0, 32'h1234, 1, 32'h24051234, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_inst_encoder.md
# dbg_inst_encoder

Debug-side MIPS instruction encoder: the inverse of the control decoder. It accepts abstract operation commands (op code plus register and immediate fields) from the debug/self-test port and encodes them into 32-bit MIPS instruction words. It expands pseudo-ops into multi-word sequences and buffers the words in a small FIFO. It drives the fetch-stage injection port through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two and at least 2.
- LVL_W, $clog2(DEPTH+1): width of the `level` output.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the FIFO and the FSM. Takes priority over all other activity.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  6  operation code (see Operation).
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields.
- cmd_imm  in  `WIDTH`  immediate field, used per op class:
  - [15:0]: I-type immediate and branch offset.
  - [4:0]: shamt.
  - [25:0]: jump target.
  - full 32 bits: LI32.
- out_valid  out  1  a word is available at the FIFO head.
- out_ready  in  1  the fetch stage consumes the head word.
- out_inst  out  `WIDTH`  head instruction word.
- level  out  LVL_W  current FIFO occupancy.
- err_illegal  out  1  one-cycle pulse when an undefined cmd_op is accepted.

## Operation
- Op codes 0–31, in this order: ADD, ADDU, SUB, SUBU, SLT, SLTU, AND, OR, XOR, NOR, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, J, JAL.
- Pseudo-ops:
  - 32 = LI32, expands to LUI rt,imm[31:16] then ORI rt,rt,imm[15:0].
  - 33 = NOP, encodes to 0x00000000.
- Codes 34–63 are illegal: the command is consumed, err_illegal pulses, and nothing is pushed.
- R-type words are {6'b0, rs, rt, rd, shamt, funct}, using standard MIPS funct values.
  - Immediate shifts: rs=0, shamt=imm[4:0].
  - Variable shifts: shamt=0.
  - JR: rt=rd=shamt=0.
  - JALR: rt=shamt=0, rd=cmd_rd.
- I-type words are {opcode, rs, rt, imm[15:0]}. LUI forces rs=0.
- J/JAL words are {opcode, imm[25:0]}.
- FSM states:
  - IDLE: cmd_ready = !full.
    - On accept of a one-word op: push the word, stay in IDLE.
    - On accept of a two-word op: push the first word, go to SECOND.
  - SECOND: cmd_ready=0. Push the second word once !full, then return to IDLE.
- FIFO behaviour:
  - out_inst/out_valid reflect the registered head entry.
  - A pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle are allowed when not full. Level is unchanged.
  - When full, no push occurs in that cycle, even if a pop occurs (no bypass).
- Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - out_valid=0, out_inst=0, level=0, err_illegal=0, state=IDLE.
  - cmd_ready=1 once out of reset.
- Latency: a command accepted in cycle N makes its first word visible at out_inst in cycle N+1. A second word becomes visible in cycle N+2 at the earliest.
- cmd_ready is combinational from state and registered level only. It does not depend on out_ready.
- flush in SECOND discards the pending word. Next cycle: level=0, state=IDLE.
- Asynchronous reset mid-sequence has the same effect as flush: no partial sequence survives.
- err_illegal is registered and asserts in cycle N+1 for an accept in cycle N.

## Configuration
- DBG_ENC_DELAY_SLOT_EN, when defined: every BEQ, BNE, J, JAL, JR and JALR becomes two-word, with a NOP (0x00000000) appended as a delay-slot word through the SECOND state.
- When undefined: branches and jumps are one word, and only LI32 uses SECOND.

## Structure
- common.vh holds:
  - `DBG_OP_*` op-code macros (6-bit).
  - MIPS opcode/funct constants shared with the control decoder.
  - `WIDTH`.
- Sub-module sync_fifo (DEPTH, `WIDTH`): push/pop/full/empty/level, with async active-low reset.
- The top level holds the combinational encoder and the two-state FSM.

## Test plan
- ADD, rs=1 rt=2 rd=3 → out_inst 0x00221820 one cycle after accept; level 1.
- ADDIU, rs=0 rt=5 imm=0x1234 → 0x24051234.
- LI32, rt=8 imm=0xDEADBEEF → 0x3C08DEAD then 0x3508BEEF; cmd_ready low for exactly one cycle.
- J, imm=0x0100000 → 0x08100000.
  - Macro defined: followed by 0x00000000.
  - Macro undefined: single word.
- Backpressure:
  - out_ready=0, push 4 NOPs → level=4, cmd_ready=0.
  - Raise out_ready → four pops in order, one per cycle; level reaches 0 and out_valid drops.
- Illegal and reset handling:
  - cmd_op=40 → err_illegal pulse, level unchanged.
  - Deassert rst_n during SECOND of LI32 → level=0, out_valid=0, and 0x3508BEEF is never emitted.
